// File: rtl/flex_counter_2d.sv
// Two-dimensional raster counter: column counter cascaded into a row counter,
// with run-time wrap values, preload, one-shot halt and a frame-done pulse.
module flex_counter_2d #(
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                count_enable,
    input  logic                one_shot,
    input  logic [COL_BITS-1:0] col_rollover_val,
    input  logic [ROW_BITS-1:0] row_rollover_val,
    input  logic                load_en,
    input  logic [COL_BITS-1:0] load_col,
    input  logic [ROW_BITS-1:0] load_row,
    output logic [COL_BITS-1:0] col_out,
    output logic [ROW_BITS-1:0] row_out,
    output logic                col_rollover_flag,
    output logic                row_rollover_flag,
    output logic                frame_done,
    output logic                halted
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [0:0]          state;
    logic [0:0]          state_next;
    logic [COL_BITS-1:0] col_next;
    logic [ROW_BITS-1:0] row_next;
    logic                col_flag_next;
    logic                row_flag_next;
    logic                frame_done_next;
    logic                col_last;
    logic                row_last;

    // >= so out-of-range preloads end the line/frame at once
    assign col_last = (col_out >= col_rollover_val);
    assign row_last = (row_out >= row_rollover_val);

    always_comb begin
        col_next        = col_out;
        row_next        = row_out;
        state_next      = state;
        frame_done_next = 1'b0;
        if (clear) begin
            col_next   = '0;
            row_next   = '0;
            state_next = RUN;
        end else if (load_en) begin
            col_next   = load_col;
            row_next   = load_row;
            state_next = RUN;
        end else if (count_enable && (state == RUN)) begin
            if (!col_last) begin
                col_next = col_out + 1'b1;
            end else if (!row_last) begin
                col_next = '0;
                row_next = row_out + 1'b1;
            end else begin
                frame_done_next = 1'b1;
                if (one_shot) begin
                    state_next = HALT;
                end else begin
                    col_next = '0;
                    row_next = '0;
                end
            end
        end
    end

    // Flags track the next counter values so they line up with col_out/row_out
    always_comb begin
        col_flag_next = 1'b0;
        row_flag_next = 1'b0;
        if (!clear) begin
            col_flag_next = (col_next >= col_rollover_val);
            row_flag_next = (row_next >= row_rollover_val);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_out           <= '0;
            row_out           <= '0;
            col_rollover_flag <= 1'b0;
            row_rollover_flag <= 1'b0;
            frame_done        <= 1'b0;
            state             <= RUN;
        end else begin
            col_out           <= col_next;
            row_out           <= row_next;
            col_rollover_flag <= col_flag_next;
            row_rollover_flag <= row_flag_next;
            frame_done        <= frame_done_next;
            state             <= state_next;
        end
    end

    assign halted = (state == HALT);

endmodule

// File: tb/tb_flex_counter_2d.sv
// Directed bench for flex_counter_2d: raster walk, one-shot halt, preload,
// priority, degenerate wrap values and enable gating.
module tb_flex_counter_2d;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       count_enable;
    logic       one_shot;
    logic [9:0] col_rollover_val;
    logic [9:0] row_rollover_val;
    logic       load_en;
    logic [9:0] load_col;
    logic [9:0] load_row;
    logic [9:0] col_out;
    logic [9:0] row_out;
    logic       col_rollover_flag;
    logic       row_rollover_flag;
    logic       frame_done;
    logic       halted;

    int compared   = 0;
    int mismatched = 0;

    flex_counter_2d #(.COL_BITS(10), .ROW_BITS(10)) dut (
        .clk               (clk),
        .rst               (rst),
        .clear             (clear),
        .count_enable      (count_enable),
        .one_shot          (one_shot),
        .col_rollover_val  (col_rollover_val),
        .row_rollover_val  (row_rollover_val),
        .load_en           (load_en),
        .load_col          (load_col),
        .load_row          (load_row),
        .col_out           (col_out),
        .row_out           (row_out),
        .col_rollover_flag (col_rollover_flag),
        .row_rollover_flag (row_rollover_flag),
        .frame_done        (frame_done),
        .halted            (halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input int r,
                             input int cf, input int rf, input int fd,
                             input int h);
        check({tag, ".col"}, int'(col_out), c);
        check({tag, ".row"}, int'(row_out), r);
        check({tag, ".col_flag"}, int'(col_rollover_flag), cf);
        check({tag, ".row_flag"}, int'(row_rollover_flag), rf);
        check({tag, ".frame_done"}, int'(frame_done), fd);
        check({tag, ".halted"}, int'(halted), h);
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        count_enable = 1'b0;
        one_shot = 1'b0;
        col_rollover_val = 10'd3;
        row_rollover_val = 10'd2;
        load_en = 1'b0;
        load_col = '0;
        load_row = '0;
        step();
        check_all("reset", 0, 0, 0, 0, 0, 0);

        // Free-running 4x3 raster
        rst = 1'b0;
        count_enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check_all($sformatf("walk%0d", i), i % 4, (i / 4) % 3,
                      int'(i % 4 == 3), int'((i / 4) % 3 == 2),
                      int'(i == 12), 0);
        end

        // One-shot: halt at (3,2)
        count_enable = 1'b0;
        clear = 1'b1;
        step();
        check_all("clr1", 0, 0, 0, 0, 0, 0);
        clear = 1'b0;
        one_shot = 1'b1;
        count_enable = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i <= 11)
                check_all($sformatf("os%0d", i), i % 4, i / 4,
                          int'(i % 4 == 3), int'(i / 4 == 2), 0, 0);
            else
                check_all($sformatf("os%0d", i), 3, 2, 1, 1,
                          int'(i == 12), 1);
        end
        count_enable = 1'b0;
        clear = 1'b1;
        step();
        check_all("clr2", 0, 0, 0, 0, 0, 0);

        // Out-of-range preload ends the line at once
        clear = 1'b0;
        one_shot = 1'b0;
        load_en = 1'b1;
        load_col = 10'd7;
        load_row = 10'd1;
        step();
        check_all("load71", 7, 1, 1, 0, 0, 0);
        load_en = 1'b0;
        count_enable = 1'b1;
        step();
        check_all("after_load", 0, 2, 0, 1, 0, 0);

        // Priority: clear beats load and enable
        count_enable = 1'b0;
        load_en = 1'b1;
        load_col = 10'd2;
        load_row = 10'd1;
        step();
        check_all("load21", 2, 1, 0, 0, 0, 0);
        clear = 1'b1;
        count_enable = 1'b1;
        step();
        check_all("prio", 0, 0, 0, 0, 0, 0);
        clear = 1'b0;
        load_en = 1'b0;
        step();
        check_all("mid1", 1, 0, 0, 0, 0, 0);
        step();
        check_all("mid2", 2, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        check_all("rst_mid", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Enable gating from (2,0)
        count_enable = 1'b0;
        load_en = 1'b1;
        load_col = 10'd2;
        load_row = 10'd0;
        step();
        check_all("load20", 2, 0, 0, 0, 0, 0);
        load_en = 1'b0;
        count_enable = 1'b1;
        step();
        check_all("tog1", 3, 0, 1, 0, 0, 0);
        count_enable = 1'b0;
        step();
        check_all("tog2", 3, 0, 1, 0, 0, 0);
        count_enable = 1'b1;
        step();
        check_all("tog3", 0, 1, 0, 0, 0, 0);
        count_enable = 1'b0;
        step();
        check_all("tog4", 0, 1, 0, 0, 0, 0);

        // Both wrap values zero: every enable is an end of frame
        col_rollover_val = 10'd0;
        row_rollover_val = 10'd0;
        clear = 1'b1;
        step();
        check_all("clr3", 0, 0, 0, 0, 0, 0);
        clear = 1'b0;
        count_enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check_all($sformatf("zero%0d", i), 0, 0, 1, 1, 1, 0);
        end
        count_enable = 1'b0;
        step();
        check_all("zero_idle", 0, 0, 1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/flex_counter_2d.md
Name: flex_counter_2d

Overview:
- Two-dimensional flexible counter: cascaded column and row counters with run-time wrap values, preload, one-shot or free-running mode, and a frame-done pulse.
- Generates raster (col,row) pixel coordinates and end-of-line/end-of-frame events for the Sobel datapath: window buffer addressing, output write addressing, frame sequencing.
- Successor to the single-dimension flexible counter.

Parameters:
- COL_BITS, 10, width of column counter and column wrap value
- ROW_BITS, 10, width of row counter and row wrap value

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- clear  input  1  synchronous zero of counters, flags and halt state
- count_enable  input  1  advance column by one this cycle
- one_shot  input  1  1 = halt at end of frame; 0 = wrap and continue
- col_rollover_val  input  COL_BITS  last column value (inclusive)
- row_rollover_val  input  ROW_BITS  last row value (inclusive)
- load_en  input  1  synchronous preload of both counters
- load_col  input  COL_BITS  column preload value
- load_row  input  ROW_BITS  row preload value
- col_out  output  COL_BITS  current column
- row_out  output  ROW_BITS  current row
- col_rollover_flag  output  1  high while col_out >= col_rollover_val
- row_rollover_flag  output  1  high while row_out >= row_rollover_val
- frame_done  output  1  one-cycle pulse after final pixel of frame
- halted  output  1  high while stopped at end of frame in one_shot mode

Behaviour:
- All outputs registered. Reset value of every output is 0.
- Update priority each cycle: rst > clear > load_en > count_enable > hold.
- Reset and clear are identical in effect: counters 0, both flags 0, frame_done 0, halted 0.
- load_en:
  - col_out <= load_col, row_out <= load_row.
  - frame_done <= 0, halted <= 0.
  - Flags reflect the loaded values in the same update.
- col_last = (col_out >= col_rollover_val); row_last = (row_out >= row_rollover_val). Comparison is >= so out-of-range values from a preload or a wrap-value change terminate the line/frame immediately, never a 2^N traversal.
- count_enable with halted = 0:
  - If !col_last: col_out +1, row unchanged.
  - If col_last && !row_last: col_out <= 0, row_out +1.
  - If col_last && row_last (end of frame): frame_done <= 1 for exactly one cycle.
    - one_shot = 0: both counters <= 0.
    - one_shot = 1: counters hold at current values; halted <= 1.
- count_enable with halted = 1: ignored. State holds until clear or load_en.
- frame_done is 0 in every cycle not following an end-of-frame advance. It never stays high across consecutive cycles unless consecutive end-of-frame advances occur (both wrap values 0, one_shot = 0).
- Flags are registered from next-state counter values, so they are valid in the same cycle as the counter value they describe: no one-cycle lag.
- Wrap values are sampled every cycle and may change mid-frame; the new value applies from the next comparison.
- Degenerate cases:
  - col_rollover_val = 0: column stays 0, row advances every enable, col_rollover_flag is constantly 1.
  - Both wrap values = 0: frame_done pulses every enable (one_shot = 0).
- Latency: one clock from count_enable/load_en/clear to outputs.
- Mode is sampled at the end-of-frame edge only. Changing one_shot while halted has no effect until clear/load_en.
- Implementation: counter/flag registers plus a 2-state controller, RUN and HALT. RUN to HALT on end-of-frame with one_shot = 1. HALT to RUN on clear or load_en. rst forces RUN.

Test Plan:
- Reset, then col_rv=3, row_rv=2, one_shot=0, enable held 12 cycles -> (col,row) walks (1,0)..(3,0),(0,1)..(3,2); cycle 12 -> (0,0) with frame_done=1 for one cycle; col_flag high exactly at col=3, row_flag high throughout row 2.
- Same config, one_shot=1, enable held 20 cycles -> stops at (3,2), frame_done single pulse, halted=1, outputs frozen; then clear -> (0,0), halted=0.
- load_en with load_col=7, load_row=1, col_rv=3, row_rv=2 -> next cycle (7,1), col_flag=1; next enable -> (0,2), row_flag=1.
- clear and load_en and count_enable all high in the same cycle from (2,1) -> (0,0), flags 0; rst asserted mid-frame with enable high -> all outputs 0 next cycle.
- col_rv=0, row_rv=0, one_shot=0, enable held 4 cycles -> counters stay (0,0), both flags 1, frame_done high each of the 4 cycles.
- Enable toggled 1,0,1,0 at (2,0) with col_rv=3 -> col 3 then holds, then 0 with row 1; no advance on idle cycles.
